// File: rtl/sample_unpacker_if.sv
// rtl/sample_unpacker_if.sv - memory read port and sample stream bundle
//
// Groups the sample-memory read port and the outgoing sample handshake.
//   mem_addr  : word address presented with mem_en
//   mem_en    : read strobe, data returns on mem_data the following cycle
//   mem_data  : 32-bit read data
//   smp_data  : unpacked sample
//   smp_valid : smp_data holds a sample
//   smp_ready : consumer accepts the sample
// master = the unpacker, slave = memory plus sample consumer.
interface sample_unpacker_if #(
  parameter int addr_width   = 11,
  parameter int sample_width = 10
);
  logic [addr_width-1:0]   mem_addr;
  logic                    mem_en;
  logic [31:0]             mem_data;
  logic [sample_width-1:0] smp_data;
  logic                    smp_valid;
  logic                    smp_ready;

  modport master (
    output mem_addr, mem_en, smp_data, smp_valid,
    input  mem_data, smp_ready
  );

  modport slave (
    input  mem_addr, mem_en, smp_data, smp_valid,
    output mem_data, smp_ready
  );
endinterface

// File: rtl/sample_unpacker.sv
// rtl/sample_unpacker.sv - reads packed sample words (circular pretrigger then main region) and streams samples
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start, abort      : begin readout (IDLE only) / cancel readout
//   circ_start_addr   : oldest pretrigger word
//   circ_max_addr     : highest word of the circular region
//   circ_words        : number of pretrigger words to read
//   main_start_addr   : first post-trigger word
//   total_samples     : number of samples to emit
//   bus (master)      : memory read port and sample stream
//   busy, done        : readout in progress / one-cycle completion pulse
module sample_unpacker #(
  parameter int addr_width       = 11,
  parameter int sample_width     = 10,
  parameter int samples_per_word = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [addr_width-1:0] circ_start_addr,
  input  logic [addr_width-1:0] circ_max_addr,
  input  logic [addr_width-1:0] circ_words,
  input  logic [addr_width-1:0] main_start_addr,
  input  logic [31:0]           total_samples,
  sample_unpacker_if.master     bus,
  output logic                  busy,
  output logic                  done
);
  localparam int slot_width = (samples_per_word > 1) ? $clog2(samples_per_word) : 1;
  localparam logic [slot_width-1:0] last_slot = slot_width'(samples_per_word - 1);

  typedef enum logic [2:0] {IDLE, REQ, LATCH, OUT, FIN} state_t;

  state_t                state_q, state_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic [addr_width-1:0] circ_left_q, circ_left_d;
  logic [addr_width-1:0] circ_max_q, circ_max_d;
  logic [addr_width-1:0] main_start_q, main_start_d;
  logic [31:0]           word_q, word_d;
  logic [31:0]           remaining_q, remaining_d;
  logic [slot_width-1:0] slot_q, slot_d;
  logic                  go;
  logic                  xfer;

  // start together with abort is a no-op; abort also blocks the transfer it coincides with
  assign go   = start && !abort;
  assign xfer = (state_q == OUT) && bus.smp_ready && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (go) state_d = (total_samples == 32'd0) ? FIN : REQ;
      REQ:     state_d = LATCH;
      LATCH:   state_d = OUT;
      OUT: begin
        if (xfer) begin
          if (remaining_q == 32'd1)   state_d = FIN;
          else if (slot_q == last_slot) state_d = REQ;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE)) state_d = IDLE;
  end

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_addr  = '0;
    bus.smp_valid = 1'b0;
    bus.smp_data  = '0;
    busy          = 1'b0;
    done          = 1'b0;
    case (state_q)
      REQ: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = addr_q;
        busy         = 1'b1;
      end
      LATCH: busy = 1'b1;
      OUT: begin
        bus.smp_valid = 1'b1;
        bus.smp_data  = word_q[32'(slot_q) * sample_width +: sample_width];
        busy          = 1'b1;
      end
      FIN:     done = 1'b1;
      default: ;
    endcase
  end

  // Address sequencing: circ_left counts pretrigger fetches still owed; the
  // fetch that brings it to zero hands the address over to the main region.
  always_comb begin
    addr_d       = addr_q;
    circ_left_d  = circ_left_q;
    circ_max_d   = circ_max_q;
    main_start_d = main_start_q;
    word_d       = word_q;
    remaining_d  = remaining_q;
    slot_d       = slot_q;
    case (state_q)
      IDLE: begin
        if (go) begin
          circ_max_d   = circ_max_addr;
          main_start_d = main_start_addr;
          circ_left_d  = circ_words;
          addr_d       = (circ_words != '0) ? circ_start_addr : main_start_addr;
          remaining_d  = total_samples;
          slot_d       = '0;
        end
      end
      REQ: begin
        if (circ_left_q != '0) begin
          circ_left_d = circ_left_q - 1'b1;
          if (circ_left_q == addr_width'(1)) addr_d = main_start_q;
          else if (addr_q == circ_max_q)     addr_d = '0;
          else                               addr_d = addr_q + 1'b1;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      LATCH: begin
        word_d = bus.mem_data;
        slot_d = '0;
      end
      OUT: begin
        if (xfer) begin
          remaining_d = remaining_q - 32'd1;
          slot_d      = (slot_q == last_slot) ? '0 : slot_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= '0;
      circ_left_q  <= '0;
      circ_max_q   <= '0;
      main_start_q <= '0;
      word_q       <= '0;
      remaining_q  <= '0;
      slot_q       <= '0;
    end else begin
      addr_q       <= addr_d;
      circ_left_q  <= circ_left_d;
      circ_max_q   <= circ_max_d;
      main_start_q <= main_start_d;
      word_q       <= word_d;
      remaining_q  <= remaining_d;
      slot_q       <= slot_d;
    end
  end
endmodule

// File: tb/tb_sample_unpacker.sv
// tb/tb_sample_unpacker.sv - directed self-checking bench for sample_unpacker
module tb_sample_unpacker;
  localparam int AW = 11;
  localparam int SW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] circ_start_addr = '0;
  logic [AW-1:0] circ_max_addr = '0;
  logic [AW-1:0] circ_words = '0;
  logic [AW-1:0] main_start_addr = '0;
  logic [31:0]   total_samples = '0;
  logic          busy;
  logic          done;

  sample_unpacker_if #(.addr_width(AW), .sample_width(SW)) bus ();

  sample_unpacker #(.addr_width(AW), .sample_width(SW), .samples_per_word(3)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .abort           (abort),
    .circ_start_addr (circ_start_addr),
    .circ_max_addr   (circ_max_addr),
    .circ_words      (circ_words),
    .main_start_addr (main_start_addr),
    .total_samples   (total_samples),
    .bus             (bus.master),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ready_mode = 0;
  logic [31:0] mem [0:2047];

  int got_addr[$];
  int got_smp[$];
  int got_cyc[$];
  int done_cyc[$];
  int ea[$];
  logic          mon_stall;
  logic [SW-1:0] mon_prev;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (bus.mem_en) bus.mem_data <= mem[bus.mem_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // smp_ready: always high, or the repeating 1,0,0,1 pattern
  initial begin
    bus.smp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.smp_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
    end
  end

  initial begin
    mon_stall = 1'b0;
    mon_prev  = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mon_stall) begin
          chk("stall_valid", 32'(bus.smp_valid), 32'd1);
          chk("stall_data", 32'(bus.smp_data), 32'(mon_prev));
        end
        if (bus.smp_valid) chk("en_in_out", 32'(bus.mem_en), 32'd0);
        if (bus.mem_en) got_addr.push_back(int'(bus.mem_addr));
        if (bus.smp_valid && bus.smp_ready && !abort) begin
          got_smp.push_back(int'(bus.smp_data));
          got_cyc.push_back(cyc);
        end
        if (done) done_cyc.push_back(cyc);
        mon_stall = bus.smp_valid && !bus.smp_ready && !abort;
        mon_prev  = bus.smp_data;
      end else begin
        mon_stall = 1'b0;
      end
    end
  end

  function automatic int exp_smp(input int i);
    logic [31:0] w;
    if (i / 3 >= ea.size()) return -1;
    w = mem[ea[i/3]];
    return int'((w >> (10 * (i % 3))) & 32'h3ff);
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got_addr.delete();
    got_smp.delete();
    got_cyc.delete();
    done_cyc.delete();
  endtask

  // called just after a clock edge; returns the start cycle, leaves config scrambled
  task automatic launch(input int cs, input int cm, input int cw, input int ms, input int tot, output int s_cyc);
    circ_start_addr = AW'(cs);
    circ_max_addr   = AW'(cm);
    circ_words      = AW'(cw);
    main_start_addr = AW'(ms);
    total_samples   = 32'(tot);
    start = 1'b1;
    s_cyc = cyc;
    sync();
    start = 1'b0;
    circ_start_addr = 11'h3aa;
    circ_max_addr   = 11'h3ab;
    circ_words      = 11'h001;
    main_start_addr = 11'h3ac;
    total_samples   = 32'd99;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done_cyc.size() == 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    chk({name, "_timeout"}, 32'(done_cyc.size() != 0), 32'd1);
    sync();
  endtask

  task automatic wait_smp(input int cnt);
    int n;
    n = 0;
    while (got_smp.size() < cnt && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("wait_smp_timeout", 32'(got_smp.size() >= cnt), 32'd1);
  endtask

  task automatic verify(input string name, input int tot, input int s_cyc, input bit lat);
    chk({name, "_naddr"}, got_addr.size(), ea.size());
    for (int i = 0; i < ea.size() && i < got_addr.size(); i++) chk({name, "_addr"}, got_addr[i], ea[i]);
    chk({name, "_nsmp"}, got_smp.size(), tot);
    for (int i = 0; i < tot && i < got_smp.size(); i++) chk({name, "_smp"}, got_smp[i], exp_smp(i));
    chk({name, "_ndone"}, done_cyc.size(), 1);
    if (done_cyc.size() == 1) begin
      if (tot == 0) chk({name, "_done_lat"}, done_cyc[0] - s_cyc, 1);
      else if (got_cyc.size() > 0) chk({name, "_done_lat"}, done_cyc[0] - got_cyc[got_cyc.size()-1], 1);
    end
    if (lat && got_cyc.size() > 0) chk({name, "_first_lat"}, got_cyc[0] - s_cyc, 3);
    chk({name, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_done"}, 32'(done), 32'd0);
    chk({name, "_mem_en"}, 32'(bus.mem_en), 32'd0);
    chk({name, "_valid"}, 32'(bus.smp_valid), 32'd0);
    chk({name, "_addr"}, 32'(bus.mem_addr), 32'd0);
    chk({name, "_data"}, 32'(bus.smp_data), 32'd0);
  endtask

  initial begin
    int s;
    for (int i = 0; i < 2048; i++)
      mem[i] = 32'hC000_0000 | 32'(((i*3+2) & 1023) << 20) | 32'(((i*3+1) & 1023) << 10) | 32'((i*3) & 1023);
    mem[5] = 32'h0C83_2064;

    repeat (3) @(posedge clk);
    #1;
    chk_quiet("reset");
    rst_n = 1'b1;
    sync();

    // basic readout from main region
    clear_mon();
    launch(0, 0, 0, 5, 6, s);
    wait_done("basic");
    ea = '{5, 6};
    verify("basic", 6, s, 1'b1);
    if (got_smp.size() >= 3) begin
      chk("basic_s0", got_smp[0], 32'h064);
      chk("basic_s1", got_smp[1], 32'h0c8);
      chk("basic_s2", got_smp[2], 32'h0c8);
    end

    // circular wrap then main; 5 words of 5 cycles each
    clear_mon();
    launch(2, 3, 3, 4, 15, s);
    wait_done("circ");
    ea = '{2, 3, 0, 4, 5};
    verify("circ", 15, s, 1'b1);
    if (got_cyc.size() == 15) chk("circ_thru", got_cyc[14] - s, 25);

    // partial last word
    clear_mon();
    launch(0, 0, 0, 10, 4, s);
    wait_done("partial");
    ea = '{10, 11};
    verify("partial", 4, s, 1'b1);

    // pretrigger longer than needed: main region never read
    clear_mon();
    launch(100, 200, 5, 50, 6, s);
    wait_done("circ_only");
    ea = '{100, 101};
    verify("circ_only", 6, s, 1'b1);

    // backpressure with wrap at the top of a one-word-past region
    ready_mode = 1;
    clear_mon();
    launch(7, 7, 2, 20, 7, s);
    wait_done("bp");
    ea = '{7, 0, 20};
    verify("bp", 7, s, 1'b0);
    ready_mode = 0;
    sync();

    // zero length
    clear_mon();
    launch(0, 0, 0, 5, 0, s);
    wait_done("zero");
    ea.delete();
    verify("zero", 0, s, 1'b0);

    // start while busy is ignored
    clear_mon();
    launch(0, 0, 0, 5, 6, s);
    sync();
    sync();
    main_start_addr = 11'd30;
    total_samples   = 32'd3;
    start = 1'b1;
    sync();
    start = 1'b0;
    wait_done("busy_start");
    ea = '{5, 6};
    verify("busy_start", 6, s, 1'b1);

    // start with abort in IDLE does nothing
    clear_mon();
    start = 1'b1;
    abort = 1'b1;
    sync();
    start = 1'b0;
    abort = 1'b0;
    repeat (4) sync();
    chk_quiet("start_abort");
    chk("start_abort_nen", got_addr.size(), 0);
    chk("start_abort_ndone", done_cyc.size(), 0);

    // abort after the second transfer, then replay
    clear_mon();
    launch(0, 0, 0, 5, 6, s);
    wait_smp(2);
    #1;
    abort = 1'b1;
    sync();
    abort = 1'b0;
    chk_quiet("abort");
    repeat (4) sync();
    chk("abort_nsmp", got_smp.size(), 2);
    chk("abort_ndone", done_cyc.size(), 0);
    clear_mon();
    launch(0, 0, 0, 5, 6, s);
    wait_done("abort_replay");
    ea = '{5, 6};
    verify("abort_replay", 6, s, 1'b1);

    // reset mid-OUT, then start on the first edge after release
    clear_mon();
    launch(0, 0, 0, 5, 6, s);
    wait_smp(1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_quiet("rst_async");
    sync();
    chk_quiet("rst_hold");
    chk("rst_ndone", done_cyc.size(), 0);
    rst_n = 1'b1;
    clear_mon();
    launch(0, 0, 0, 5, 6, s);
    wait_done("rst_replay");
    ea = '{5, 6};
    verify("rst_replay", 6, s, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
